sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
Shares the single-port instruction/data SRAM between the IF stage (instruction fetch, read-only) and the MEM stage (loads and stores). It arbitrates with a valid/ready handshake and drives the SRAM port. It returns read data to the winning stage one cycle later and tracks the single outstanding read. MEM has priority; a streak counter guarantees IF forward progress.

Parameters:
ADDR_W, 32, address width of all requesters and the SRAM
DATA_W, 32, data width; byte-enable width is DATA_W/8
MAX_MEM_STREAK, 4, maximum consecutive MEM grants while IF waits; 0 = strict MEM priority, no fairness

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
if_req  input  1  IF read request, held until accepted
if_addr  input  ADDR_W  IF fetch address
if_ready  output  1  IF request accepted this cycle
if_rvalid  output  1  IF read data valid, 1-cycle pulse
if_rdata  output  DATA_W  IF read data
mem_req  input  1  MEM request, held until accepted
mem_we  input  DATA_W/8  byte write enables; 0 = load, nonzero = store
mem_addr  input  ADDR_W  MEM address
mem_wdata  input  DATA_W  store data
mem_ready  output  1  MEM request accepted this cycle
mem_rvalid  output  1  MEM load data valid, 1-cycle pulse
mem_rdata  output  DATA_W  MEM load data
sram_en  output  1  SRAM access enable
sram_we  output  DATA_W/8  SRAM byte write enables
sram_addr  output  ADDR_W  SRAM address
sram_wdata  output  DATA_W  SRAM write data
sram_rdata  input  DATA_W  SRAM read data, valid the cycle after a read-enabled edge

Behaviour:
- FSM states: IDLE and RESP. Reset value is IDLE. Other state: resp_is_mem (1 bit) and mem_streak (0..MAX_MEM_STREAK), both reset to 0.
- While reset is low, all outputs are 0: ready, rvalid, sram_en, sram_we. rdata and sram_addr/wdata are also 0.
- Transfer occurs when req && ready in the same cycle. A requester holds req, addr, we and wdata stable until ready.
- IDLE arbitration (combinational, same cycle):
  - Fairness override: if if_req && MAX_MEM_STREAK!=0 && mem_streak==MAX_MEM_STREAK, IF wins.
  - Otherwise, if mem_req, MEM wins.
  - Otherwise, if if_req, IF wins.
  - Otherwise, no grant.
- On a grant: the winner's ready=1; sram_en=1; sram_addr, sram_we and sram_wdata come from the winner. IF grants always drive sram_we=0.
- Loser ready=0. In RESP, both ready=0 and sram_en=0.
- Store grant (mem_we!=0): completes at the edge; the FSM stays IDLE; no rvalid. Back-to-back stores give 1 grant/cycle.
- Read grant (IF, or MEM with mem_we==0): the FSM goes to IDLE->RESP and resp_is_mem is latched to the winner.
- RESP lasts exactly 1 cycle:
  - The selected rvalid=1 and its rdata=sram_rdata, passed through combinationally. The other rvalid=0.
  - RESP->IDLE unconditionally.
  - Read throughput is 1 per 2 cycles; read latency is grant edge + 1 cycle.
  - The requester must consume data in the rvalid cycle; there is no backpressure.
- Unselected rdata outputs drive 0.
- mem_streak update, on every IDLE edge:
  - MEM grant while if_req=1: +1, saturating at MAX_MEM_STREAK.
  - IF grant, or if_req=0: clear to 0.
  - In RESP: hold.
- Simultaneous if_req and mem_req in IDLE: MEM wins unless the fairness override applies.
- A request deasserted before acceptance is a protocol violation; the block needs no defined behaviour for it.
- Reset asserted mid-read (in RESP): the FSM returns to IDLE immediately. No rvalid is produced for the dropped read after reset release.
- sram_rdata is ignored outside RESP.

Decomposition:
- Shared cpu package holds:
  - state encoding localparams (ST_IDLE, ST_RESP)
  - ADDR_W/DATA_W defaults
  - requester ID constants (REQ_IF=0, REQ_MEM=1)
- One natural sub-module, arb_fair_pick: the combinational winner selection plus the mem_streak saturating counter. The top level keeps the FSM and muxes.

Test Plan:
- Reset/idle: reset=0 with if_req=1 and mem_req=1 -> all ready/rvalid/sram_en=0. After release, FSM=IDLE and the first grant goes to MEM.
- IF read alone: if_req=1, if_addr=0x1C000000. Cycle 0: if_ready=1, sram_en=1, sram_we=0. Cycle 1: sram_rdata=0x02800C00 gives if_rvalid=1, if_rdata=0x02800C00, if_ready=0.
- Store then load: mem_we=0xF store to 0x100 with wdata 0xDEADBEEF, then mem_we=0 load from 0x100. Expect 2 consecutive grants with no idle cycle; mem_rvalid one cycle after the load grant.
- Fairness: MAX_MEM_STREAK=4, mem_req held with stores, if_req held at 1 -> grants MEM,MEM,MEM,MEM,IF,MEM... and mem_streak returns to 0 after the IF grant.
- Strict mode: MAX_MEM_STREAK=0 with both requests continuously asserted -> IF never granted over 20 cycles.
- Reset mid-read: MEM load granted, reset pulled low in the RESP cycle -> mem_rvalid=0 throughout, FSM=IDLE after release, no stale rvalid.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port SRAM arbiter.
package sram_port_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/arb_fair_pick.sv
// Winner selection between IF and MEM: MEM first, but IF is forced through
// after MAX_MEM_STREAK back-to-back MEM grants it had to sit out.
module arb_fair_pick
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_MEM_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic if_req,
    input  logic mem_req,
    output logic grant_if,
    output logic grant_mem
);

    localparam int unsigned STREAK_W = (MAX_MEM_STREAK > 0) ? $clog2(MAX_MEM_STREAK + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);

    logic [STREAK_W-1:0] mem_streak;
    logic                fair_if;

    assign fair_if   = if_req && (MAX_MEM_STREAK != 0) && (mem_streak == STREAK_MAX);
    assign grant_mem = arb_en && mem_req && !fair_if;
    assign grant_if  = arb_en && (fair_if || (if_req && !mem_req));

    // Counts MEM wins that left IF waiting; frozen while a read response is out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_streak <= '0;
        end else if (arb_en) begin
            if (grant_mem && if_req) begin
                if (mem_streak != STREAK_MAX) begin
                    mem_streak <= mem_streak + STREAK_W'(1);
                end
            end else begin
                mem_streak <= '0;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM shared by instruction fetch and load/store; one outstanding
// read, data returned combinationally from the SRAM in the response cycle.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned MAX_MEM_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                mem_req,
    input  logic [DATA_W/8-1:0] mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_ready,
    output logic                mem_rvalid,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    state_t state;
    logic   resp_is_mem;
    logic   arb_en;
    logic   grant_if;
    logic   grant_mem;
    logic   read_grant;

    assign arb_en     = reset && (state == ST_IDLE);
    assign read_grant = grant_if || (grant_mem && (mem_we == '0));

    arb_fair_pick #(
        .MAX_MEM_STREAK(MAX_MEM_STREAK)
    ) u_pick (
        .clk       (clk),
        .reset     (reset),
        .arb_en    (arb_en),
        .if_req    (if_req),
        .mem_req   (mem_req),
        .grant_if  (grant_if),
        .grant_mem (grant_mem)
    );

    // Stores retire at the grant edge; only reads spend a cycle in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            resp_is_mem <= REQ_IF;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (read_grant) begin
                        state       <= ST_RESP;
                        resp_is_mem <= grant_mem ? REQ_MEM : REQ_IF;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake and SRAM port are decoded in the same cycle as the request.
    always_comb begin
        if_ready   = 1'b0;
        if_rvalid  = 1'b0;
        if_rdata   = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        sram_en    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (reset) begin
            if (state == ST_IDLE) begin
                if (grant_mem) begin
                    mem_ready  = 1'b1;
                    sram_en    = 1'b1;
                    sram_we    = mem_we;
                    sram_addr  = mem_addr;
                    sram_wdata = mem_wdata;
                end else if (grant_if) begin
                    if_ready  = 1'b1;
                    sram_en   = 1'b1;
                    sram_addr = if_addr;
                end
            end else if (resp_is_mem == REQ_MEM) begin
                mem_rvalid = 1'b1;
                mem_rdata  = sram_rdata;
            end else begin
                if_rvalid = 1'b1;
                if_rdata  = sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: a fairness instance (streak 4) and a strict-priority instance
// (streak 0) share the same stimulus.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] sram_rdata;

    logic        a_if_ready, a_if_rvalid, a_mem_ready, a_mem_rvalid, a_sram_en;
    logic [31:0] a_if_rdata, a_mem_rdata, a_sram_addr, a_sram_wdata;
    logic [3:0]  a_sram_we;
    logic        b_if_ready, b_if_rvalid, b_mem_ready, b_mem_rvalid, b_sram_en;
    logic [31:0] b_if_rdata, b_mem_rdata, b_sram_addr, b_sram_wdata;
    logic [3:0]  b_sram_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_MEM_STREAK(4)) dut_fair (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(a_if_ready),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(a_mem_ready), .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata),
        .sram_en(a_sram_en), .sram_we(a_sram_we), .sram_addr(a_sram_addr),
        .sram_wdata(a_sram_wdata), .sram_rdata(sram_rdata)
    );

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_MEM_STREAK(0)) dut_strict (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(b_if_ready),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(b_mem_ready), .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata),
        .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_addr(b_sram_addr),
        .sram_wdata(b_sram_wdata), .sram_rdata(sram_rdata)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        mem_req;
        logic [3:0]  mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] sram_rdata;
        logic        x_if_ready;
        logic        x_mem_ready;
        logic        x_if_rvalid;
        logic        x_mem_rvalid;
        logic        x_sram_en;
        logic [3:0]  x_sram_we;
        logic [31:0] x_sram_addr;
        logic [31:0] x_sram_wdata;
        logic [31:0] x_if_rdata;
        logic [31:0] x_mem_rdata;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic mr, input logic [3:0] mw,
        input logic [31:0] ma, input logic [31:0] md, input logic [31:0] sr,
        input logic xir, input logic xmr, input logic xiv, input logic xmv, input logic xen,
        input logic [3:0] xwe, input logic [31:0] xa, input logic [31:0] xd,
        input logic [31:0] xird, input logic [31:0] xmrd);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.mem_req = mr; v.mem_we = mw;
        v.mem_addr = ma; v.mem_wdata = md; v.sram_rdata = sr;
        v.x_if_ready = xir; v.x_mem_ready = xmr; v.x_if_rvalid = xiv; v.x_mem_rvalid = xmv;
        v.x_sram_en = xen; v.x_sram_we = xwe; v.x_sram_addr = xa; v.x_sram_wdata = xd;
        v.x_if_rdata = xird; v.x_mem_rdata = xmrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic mr,
                         input logic [3:0] mw, input logic [31:0] ma,
                         input logic [31:0] md, input logic [31:0] sr);
        @(negedge clk);
        if_req = ir; if_addr = ia; mem_req = mr; mem_we = mw;
        mem_addr = ma; mem_wdata = md; sram_rdata = sr;
        #2;
    endtask

    initial begin
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h0; mem_req = 1'b1; mem_we = 4'hF;
        mem_addr = 32'h0; mem_wdata = 32'h0; sram_rdata = 32'h0;

        // Reset holds every output low even with both requests pending.
        @(negedge clk); #2;
        chk("rst a_if_ready", 32'(a_if_ready), 32'd0);
        chk("rst a_mem_ready", 32'(a_mem_ready), 32'd0);
        chk("rst a_sram_en", 32'(a_sram_en), 32'd0);
        chk("rst a_rvalid", 32'({a_if_rvalid, a_mem_rvalid}), 32'd0);
        chk("rst b_ready", 32'({b_if_ready, b_mem_ready}), 32'd0);
        chk("rst b_sram_en", 32'(b_sram_en), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        chk("first grant a_mem_ready", 32'(a_mem_ready), 32'd1);
        chk("first grant a_if_ready", 32'(a_if_ready), 32'd0);

        //         if_req if_addr       mem mw    mem_addr      wdata         sram_rdata      ir mr iv mv en we    addr          wdata         if_rdata      mem_rdata
        vecs[0]  = mk(0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h00000055, 0, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h0);
        vecs[1]  = mk(1, 32'h1C000000, 0, 4'h0, 32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 1, 4'h0, 32'h1C000000, 32'h0,        32'h0,        32'h0);
        vecs[2]  = mk(0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h02800C00, 0, 0, 1, 0, 0, 4'h0, 32'h0,        32'h0,        32'h02800C00, 32'h0);
        vecs[3]  = mk(0, 32'h0,        1, 4'hF, 32'h100,      32'hDEADBEEF, 32'h0,        0, 1, 0, 0, 1, 4'hF, 32'h100,      32'hDEADBEEF, 32'h0,        32'h0);
        vecs[4]  = mk(0, 32'h0,        1, 4'h0, 32'h100,      32'h0,        32'h0,        0, 1, 0, 0, 1, 4'h0, 32'h100,      32'h0,        32'h0,        32'h0);
        vecs[5]  = mk(1, 32'h40,       1, 4'h3, 32'h200,      32'h1234,     32'hDEADBEEF, 0, 0, 0, 1, 0, 4'h0, 32'h0,        32'h0,        32'h0,        32'hDEADBEEF);
        vecs[6]  = mk(1, 32'h40,       1, 4'h3, 32'h200,      32'h1234,     32'h0,        0, 1, 0, 0, 1, 4'h3, 32'h200,      32'h1234,     32'h0,        32'h0);
        vecs[7]  = mk(1, 32'h40,       0, 4'h0, 32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 1, 4'h0, 32'h40,       32'h0,        32'h0,        32'h0);
        vecs[8]  = mk(0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'hCAFEF00D, 0, 0, 1, 0, 0, 4'h0, 32'h0,        32'h0,        32'hCAFEF00D, 32'h0);
        vecs[9]  = mk(0, 32'h0,        1, 4'h0, 32'h300,      32'h0,        32'h00000777, 0, 1, 0, 0, 1, 4'h0, 32'h300,      32'h0,        32'h0,        32'h0);
        vecs[10] = mk(0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h12345678, 0, 0, 0, 1, 0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h12345678);

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].mem_req, vecs[i].mem_we,
                  vecs[i].mem_addr, vecs[i].mem_wdata, vecs[i].sram_rdata);
            chk($sformatf("v%0d if_ready", i), 32'(a_if_ready), 32'(vecs[i].x_if_ready));
            chk($sformatf("v%0d mem_ready", i), 32'(a_mem_ready), 32'(vecs[i].x_mem_ready));
            chk($sformatf("v%0d if_rvalid", i), 32'(a_if_rvalid), 32'(vecs[i].x_if_rvalid));
            chk($sformatf("v%0d mem_rvalid", i), 32'(a_mem_rvalid), 32'(vecs[i].x_mem_rvalid));
            chk($sformatf("v%0d sram_en", i), 32'(a_sram_en), 32'(vecs[i].x_sram_en));
            chk($sformatf("v%0d sram_we", i), 32'(a_sram_we), 32'(vecs[i].x_sram_we));
            chk($sformatf("v%0d sram_addr", i), a_sram_addr, vecs[i].x_sram_addr);
            chk($sformatf("v%0d sram_wdata", i), a_sram_wdata, vecs[i].x_sram_wdata);
            chk($sformatf("v%0d if_rdata", i), a_if_rdata, vecs[i].x_if_rdata);
            chk($sformatf("v%0d mem_rdata", i), a_mem_rdata, vecs[i].x_mem_rdata);
        end

        // Fairness: four MEM stores, forced IF read, its RESP cycle, then repeat.
        begin
            int pat[11] = '{1, 1, 1, 1, 2, 0, 1, 1, 1, 1, 2};
            for (int c = 0; c < 11; c++) begin
                drive(1, 32'h80, 1, 4'hF, 32'h400, 32'h5555AAAA, 32'h0);
                chk($sformatf("fair c%0d mem_ready", c), 32'(a_mem_ready), 32'(pat[c] == 1));
                chk($sformatf("fair c%0d if_ready", c), 32'(a_if_ready), 32'(pat[c] == 2));
                if (pat[c] == 2) chk($sformatf("fair c%0d sram_addr", c), a_sram_addr, 32'h80);
            end
        end
        drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'hA5A5A5A5);
        chk("fair resp if_rvalid", 32'(a_if_rvalid), 32'd1);
        chk("fair resp if_rdata", a_if_rdata, 32'hA5A5A5A5);

        // Strict priority: IF starves behind continuous MEM stores.
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drive(1, 32'h80, 1, 4'hF, 32'h600, 32'h0, 32'h0);
            chk($sformatf("strict c%0d if_ready", c), 32'(b_if_ready), 32'd0);
            chk($sformatf("strict c%0d mem_ready", c), 32'(b_mem_ready), 32'd1);
        end

        // Reset during the response cycle drops the read entirely.
        drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        drive(0, 32'h0, 1, 4'h0, 32'h500, 32'h0, 32'h0);
        chk("midrst load grant", 32'(a_mem_ready), 32'd1);
        @(negedge clk);
        mem_req = 1'b0; sram_rdata = 32'h99; reset = 1'b0;
        #2;
        chk("midrst rvalid in reset", 32'(a_mem_rvalid), 32'd0);
        chk("midrst rdata in reset", a_mem_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        chk("midrst rvalid after release", 32'(a_mem_rvalid), 32'd0);
        chk("midrst if_rvalid after release", 32'(a_if_rvalid), 32'd0);
        drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h99);
        chk("midrst rvalid later", 32'(a_mem_rvalid), 32'd0);
        drive(0, 32'h0, 1, 4'hF, 32'h700, 32'h11, 32'h0);
        chk("midrst idle accepts", 32'(a_mem_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
